// File: rtl/reg8_pkg.sv
// Shared types and constants for the 8-entry register-file scanner.
package reg8_pkg;

  localparam int REG_COUNT = 8;
  localparam int IDX_W     = 3;
  localparam int DATA_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_LATCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Register index advance; wraps from the top entry back to entry 0.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return IDX_W'((32'(idx) + 32'd1) % REG_COUNT);
  endfunction

endpackage

// File: rtl/reg8_reader.sv
// Scans a contiguous (wrapping) range of reg8file entries and streams each
// byte out over a valid/ready handshake, pulsing done after the last one.
module reg8_reader
  import reg8_pkg::*;
(
  input  logic              clk,
  input  logic              clrn,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W-1:0]  first,
  input  logic [IDX_W-1:0]  last,
  output logic [IDX_W-1:0]  rsel,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  state_t            state_r;
  state_t            state_s;
  logic [IDX_W-1:0]  ptr_r;
  logic [IDX_W-1:0]  ptr_s;
  logic [IDX_W-1:0]  last_r;
  logic              capture_s;

  // Next-state and pointer logic; abort outranks every other transition.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!abort && start) begin
          state_s   = ST_ISSUE;
          ptr_s     = first;
          capture_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (out_ready) begin
          if (out_idx == last_r) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ISSUE;
            ptr_s   = idx_inc(ptr_r);
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs, all decoded from the next state
  // so every output changes on the same edge as the state it belongs to.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_r   <= ST_IDLE;
      ptr_r     <= '0;
      last_r    <= '0;
      rsel      <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      if (capture_s) begin
        last_r <= last;
      end
      // rsel only moves on entry to ISSUE and otherwise holds.
      if (state_s == ST_ISSUE) begin
        rsel <= ptr_s;
      end
      if (state_r == ST_LATCH && state_s == ST_SEND) begin
        out_data <= rdata;
        out_idx  <= ptr_r;
      end
      out_valid <= (state_s == ST_SEND);
      busy      <= (state_s != ST_IDLE);
      done      <= (state_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_reg8_reader.sv
// Directed bench for reg8_reader with a behavioural write-before-read reg8file.
module tb_reg8_reader;
  import reg8_pkg::*;

  logic              clk = 1'b0;
  logic              clrn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [2:0]        first = 3'd0;
  logic [2:0]        last = 3'd0;
  logic [2:0]        rsel;
  logic [7:0]        rdata;
  logic [7:0]        out_data;
  logic [2:0]        out_idx;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              done;

  logic              we = 1'b0;
  logic [2:0]        waddr = 3'd0;
  logic [7:0]        wdata = 8'd0;
  logic [7:0]        regs [0:7];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Register file: registered read, a same-edge write is forwarded to q.
  always @(posedge clk) begin
    if (we) regs[waddr] <= wdata;
    rdata <= (we && waddr == rsel) ? wdata : regs[rsel];
  end

  reg8_reader dut (
    .clk       (clk),
    .clrn      (clrn),
    .start     (start),
    .abort     (abort),
    .first     (first),
    .last      (last),
    .rsel      (rsel),
    .rdata     (rdata),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full scan with out_ready high; optional start/first/last poke mid-scan.
  task automatic scan(input logic [2:0] f, input logic [2:0] l, input int nbytes, input bit poke);
    int n;
    int k;
    logic [2:0] eidx;
    bit seen_done;
    first = f; last = l; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    chk("first_issue_busy", busy, 1);
    chk("first_issue_rsel", rsel, f);
    n = 0; k = 0; seen_done = 1'b0;
    while (!seen_done && n < 60) begin
      if (poke && n == 4) begin
        start = 1'b1; first = f + 3'd2; last = f + 3'd2;
      end else begin
        start = 1'b0;
      end
      if (out_valid === 1'b1) begin
        eidx = f + k[2:0];
        chk("byte_idx", out_idx, eidx);
        chk("byte_data", out_data, 32'h10 + eidx);
        k++;
      end
      if (done === 1'b1) begin
        seen_done = 1'b1;
      end else begin
        step();
        n++;
      end
    end
    start = 1'b0;
    chk("done_seen", seen_done, 1);
    chk("done_cycle", n, 3 * nbytes);
    chk("byte_count", k, nbytes);
    step();
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    // Reset while preloading the register file with 0x10+i.
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; waddr = i[2:0]; wdata = 8'h10 + i[7:0];
      step();
    end
    we = 1'b0;
    chk("rst_rsel", rsel, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    clrn = 1'b1;
    step();

    // Full 0..7 scan, then a wrapping 6..1 scan.
    scan(3'd0, 3'd7, 8, 1'b0);
    scan(3'd6, 3'd1, 4, 1'b0);

    // Single byte with a stalled consumer.
    first = 3'd3; last = 3'd3; out_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("stall_valid", out_valid, 1);
    chk("stall_data", out_data, 8'h13);
    chk("stall_idx", out_idx, 3);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold_valid", out_valid, 1);
      chk("stall_hold_data", out_data, 8'h13);
      chk("stall_rsel_hold", rsel, 3);
    end
    out_ready = 1'b1;
    step();
    chk("stall_xfer_valid", out_valid, 0);
    chk("stall_done", done, 1);
    step();
    chk("stall_done_pulse", done, 0);

    // Abort in SEND of the second byte, with a simultaneous transfer.
    first = 3'd0; last = 3'd7; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("pre_abort_valid", out_valid, 1);
    chk("pre_abort_idx", out_idx, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_rsel_hold", rsel, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", done, 0);
    end
    scan(3'd0, 3'd0, 1, 1'b0);

    // Reset during LATCH, reset overriding start, abort beating start.
    first = 3'd0; last = 3'd7; start = 1'b1;
    step();
    start = 1'b0;
    step();
    clrn = 1'b0;
    step();
    chk("mid_rst_rsel", rsel, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_idx", out_idx, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    start = 1'b1;
    step();
    chk("rst_over_start", busy, 0);
    clrn = 1'b1; abort = 1'b1;
    step();
    chk("abort_over_start", busy, 0);
    start = 1'b0; abort = 1'b0;
    scan(3'd2, 3'd4, 3, 1'b1);

    // Write to reg 5 on the edge that ends its ISSUE cycle.
    first = 3'd5; last = 3'd5; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("wr_issue_rsel", rsel, 5);
    we = 1'b1; waddr = 3'd5; wdata = 8'hAB;
    step();
    we = 1'b0;
    step();
    chk("wr_fwd_valid", out_valid, 1);
    chk("wr_fwd_data", out_data, 8'hAB);
    step();
    chk("wr_fwd_done", done, 1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
